// File: rtl/rat_io_pkg.sv
// Port map and control/status bit positions shared by the RAT port responder.
package rat_io_pkg;

    localparam logic [7:0] PORT_OUT0   = 8'h00;
    localparam logic [7:0] PORT_OUT1   = 8'h01;
    localparam logic [7:0] PORT_OUT2   = 8'h02;
    localparam logic [7:0] PORT_OUT3   = 8'h03;
    localparam logic [7:0] PORT_TX     = 8'h10;
    localparam logic [7:0] PORT_CTRL   = 8'h11;
    localparam logic [7:0] PORT_RLD_LO = 8'h12;
    localparam logic [7:0] PORT_RLD_HI = 8'h13;
    localparam logic [7:0] PORT_SW     = 8'h20;
    localparam logic [7:0] PORT_STATUS = 8'h21;
    localparam logic [7:0] PORT_TXCNT  = 8'h22;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_ACK      = 1;
    localparam int CTRL_OVF_CLR  = 2;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_PENDING  = 3;
    localparam int ST_TIMER_EN = 4;

endpackage

// File: rtl/rat_port_responder_if.sv
// CPU port bus plus the TX drain handshake; master is the CPU/consumer side.
interface rat_port_responder_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output port_id, out_port, io_strb, tx_ready,
        input  in_port, tx_data, tx_valid
    );

    modport slave (
        input  port_id, out_port, io_strb, tx_ready,
        output in_port, tx_data, tx_valid
    );
endinterface

// File: rtl/rat_io_fifo.sv
// Synchronous first-word-fall-through FIFO with sticky overflow flag.
module rat_io_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (push && !do_push) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rat_port_responder.sv
// Port I/O responder for the RAT CPU: output latches, TX FIFO and optional timer.
// The interval timer and its interrupt are built only when RAT_IO_TIMER_EN is defined.
module rat_port_responder
    import rat_io_pkg::*;
#(
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [15:0] TIMER_RELOAD_RST = 16'd49999
) (
    input  logic                       clk,
    input  logic                       rst_n,
    rat_port_responder_if.slave        bus,
    input  logic [7:0]                 sw_in,
    output logic [7:0]                 out_reg0,
    output logic [7:0]                 out_reg1,
    output logic [7:0]                 out_reg2,
    output logic [7:0]                 out_reg3,
    output logic                       int_out
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             ctrl_wr;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_ovf;
    logic [CNT_W-1:0] tx_count;
    logic             timer_en;
    logic             pending;
    logic [7:0]       status;

    assign ctrl_wr = bus.io_strb && (bus.port_id == PORT_CTRL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg0 <= 8'h00;
            out_reg1 <= 8'h00;
            out_reg2 <= 8'h00;
            out_reg3 <= 8'h00;
        end else if (bus.io_strb) begin
            case (bus.port_id)
                PORT_OUT0: out_reg0 <= bus.out_port;
                PORT_OUT1: out_reg1 <= bus.out_port;
                PORT_OUT2: out_reg2 <= bus.out_port;
                PORT_OUT3: out_reg3 <= bus.out_port;
                default:   ;
            endcase
        end
    end

    rat_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.io_strb && (bus.port_id == PORT_TX)),
        .push_data (bus.out_port),
        .pop       (bus.tx_ready),
        .ovf_clr   (ctrl_wr && bus.out_port[CTRL_OVF_CLR]),
        .head      (bus.tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .ovf       (tx_ovf)
    );

    assign bus.tx_valid = !tx_empty;

`ifdef RAT_IO_TIMER_EN
    logic [15:0] reload;
    logic [15:0] counter;
    logic        expiry;
    logic        ack;
    logic        int_q;

    assign expiry  = timer_en && (counter == 16'd0);
    assign ack     = ctrl_wr && bus.out_port[CTRL_ACK];
    assign int_out = int_q;

    // Reload writes only land in the register; the running count picks them up at the next expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_en <= 1'b0;
            reload   <= TIMER_RELOAD_RST;
            counter  <= TIMER_RELOAD_RST;
            pending  <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                timer_en <= bus.out_port[CTRL_TIMER_EN];
            end
            if (bus.io_strb && (bus.port_id == PORT_RLD_LO)) begin
                reload[7:0] <= bus.out_port;
            end
            if (bus.io_strb && (bus.port_id == PORT_RLD_HI)) begin
                reload[15:8] <= bus.out_port;
            end
            if (ctrl_wr && bus.out_port[CTRL_TIMER_EN] && !timer_en) begin
                counter <= reload;
            end else if (timer_en) begin
                counter <= expiry ? reload : counter - 16'd1;
            end
            pending <= expiry | (pending & ~ack);
            int_q   <= expiry & (~pending | ack);
        end
    end
`else
    assign timer_en = 1'b0;
    assign pending  = 1'b0;
    assign int_out  = 1'b0;
`endif

    assign status = {3'b000, timer_en, pending, tx_ovf, tx_full, tx_empty};

    always_comb begin
        bus.in_port = 8'h00;
        case (bus.port_id)
            PORT_SW:     bus.in_port = sw_in;
            PORT_STATUS: bus.in_port = status;
            PORT_TXCNT:  bus.in_port = 8'(tx_count);
            PORT_CTRL:   bus.in_port = {7'b0, timer_en};
            default:     bus.in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rat_port_responder.sv
// Directed self-checking bench for rat_port_responder; timer checks follow RAT_IO_TIMER_EN.
module tb_rat_port_responder;
    import rat_io_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw_in;
    logic [7:0] out_reg0, out_reg1, out_reg2, out_reg3;
    logic       int_out;
    int         vectors;
    int         miscompares;

    rat_port_responder_if bus();

    rat_port_responder #(
        .FIFO_DEPTH       (8),
        .TIMER_RELOAD_RST (16'd49999)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .sw_in    (sw_in),
        .out_reg0 (out_reg0),
        .out_reg1 (out_reg1),
        .out_reg2 (out_reg2),
        .out_reg3 (out_reg3),
        .int_out  (int_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered and left at 1 time unit after a rising edge; the write lands on that edge.
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        bus.io_strb  = 1'b1;
        bus.port_id  = addr;
        bus.out_port = data;
        @(posedge clk);
        #1;
        bus.io_strb  = 1'b0;
        bus.port_id  = 8'hFF;
        bus.out_port = 8'h00;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
        bus.port_id = addr;
        #1;
        data = bus.in_port;
        bus.port_id = 8'hFF;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        vectors++;
        if ({out_reg0, out_reg1, out_reg2, out_reg3} !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_regs: got %h expected 00000000", {out_reg0, out_reg1, out_reg2, out_reg3});
        end
        vectors++;
        if ({bus.tx_valid, bus.tx_data, int_out} !== 10'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_tx_int: valid=%b data=%h int=%b expected 0/00/0", bus.tx_valid, bus.tx_data, int_out);
        end
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %h expected 01", rd);
        end
        io_read(PORT_TXCNT, rd);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_count: got %h expected 00", rd);
        end
    endtask

    task automatic test_latches();
        logic [7:0] rd;
        io_write(PORT_OUT0, 8'h11);
        io_write(PORT_OUT2, 8'hA5);
        vectors++;
        if ({out_reg0, out_reg1, out_reg2, out_reg3} !== 32'h1100A500) begin
            miscompares++;
            $display("[TB] FAIL latch_write: got %h expected 1100a500", {out_reg0, out_reg1, out_reg2, out_reg3});
        end
        io_write(8'h07, 8'hFF);
        io_write(PORT_OUT3, 8'h3C);
        vectors++;
        if ({out_reg0, out_reg1, out_reg2, out_reg3} !== 32'h1100A53C) begin
            miscompares++;
            $display("[TB] FAIL latch_unmapped: got %h expected 1100a53c", {out_reg0, out_reg1, out_reg2, out_reg3});
        end
        sw_in = 8'h5A;
        io_read(PORT_SW, rd);
        vectors++;
        if (rd !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL read_sw: got %h expected 5a", rd);
        end
        io_read(8'h55, rd);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL read_unmapped: got %h expected 00", rd);
        end
    endtask

    task automatic test_fifo_fill_drain();
        logic [7:0] rd;
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) io_write(PORT_TX, 8'(i));
        io_read(PORT_TXCNT, rd);
        vectors++;
        if (rd !== 8'h08) begin
            miscompares++;
            $display("[TB] FAIL fill_count: got %h expected 08", rd);
        end
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h06) begin
            miscompares++;
            $display("[TB] FAIL fill_status: got %h expected 06", rd);
        end
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL drain_byte%0d: valid=%b data=%h expected 1/%h", i, bus.tx_valid, bus.tx_data, 8'(i));
            end
            @(posedge clk);
            #1;
        end
        bus.tx_ready = 1'b0;
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h05 || bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_status: got %h valid=%b expected 05 valid=0", rd, bus.tx_valid);
        end
        io_write(PORT_CTRL, 8'h04);
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear: got %h expected 01", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic [7:0] exp;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) io_write(PORT_TX, 8'h30 + 8'(i));
        bus.tx_ready = 1'b1;
        io_write(PORT_TX, 8'h55);
        bus.tx_ready = 1'b0;
        io_read(PORT_TXCNT, rd);
        vectors++;
        if (rd !== 8'h08) begin
            miscompares++;
            $display("[TB] FAIL simul_count: got %h expected 08", rd);
        end
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL simul_status: got %h expected 02", rd);
        end
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp = (i == 8) ? 8'h55 : 8'h30 + 8'(i);
            vectors++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin
                miscompares++;
                $display("[TB] FAIL simul_byte%0d: valid=%b data=%h expected 1/%h", i, bus.tx_valid, bus.tx_data, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.tx_ready = 1'b0;
        vectors++;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL simul_empty: valid=%b expected 0", bus.tx_valid);
        end
    endtask

`ifdef RAT_IO_TIMER_EN
    task automatic test_timer();
        logic [7:0] rd;
        int n;
        io_write(PORT_RLD_LO, 8'd3);
        io_write(PORT_RLD_HI, 8'd0);
        io_write(PORT_CTRL, 8'h01);
        n = 0;
        while (int_out !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("[TB] FAIL timer_first_pulse: got %0d cycles expected 4", n);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (int_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timer_pulse_width: got %b expected 0", int_out);
        end
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (int_out === 1'b1) n++;
        end
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("[TB] FAIL timer_no_ack_pulses: got %0d expected 0", n);
        end
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h19) begin
            miscompares++;
            $display("[TB] FAIL timer_pending_status: got %h expected 19", rd);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        io_write(PORT_CTRL, 8'h03);
        vectors++;
        if (int_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timer_ack_on_expiry: got %b expected 1", int_out);
        end
        io_write(PORT_CTRL, 8'h00);
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h09 || int_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timer_disable: status=%h int=%b expected 09/0", rd, int_out);
        end
        io_write(PORT_CTRL, 8'h02);
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL timer_ack_clear: got %h expected 01", rd);
        end
    endtask
`else
    task automatic test_macro_off();
        logic [7:0] rd;
        int n;
        io_write(PORT_RLD_LO, 8'd0);
        io_write(PORT_CTRL, 8'h03);
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (int_out !== 1'b0) n++;
        end
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("[TB] FAIL macro_off_int: got %0d high cycles expected 0", n);
        end
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL macro_off_status: got %h expected 01", rd);
        end
        io_read(PORT_CTRL, rd);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL macro_off_ctrl: got %h expected 00", rd);
        end
    endtask
`endif

    task automatic test_reset_midop();
        logic [7:0] rd;
        int n;
        bus.tx_ready = 1'b0;
        io_write(PORT_TX, 8'hA1);
        io_write(PORT_TX, 8'hA2);
        io_write(PORT_TX, 8'hA3);
        io_write(PORT_OUT1, 8'h77);
`ifdef RAT_IO_TIMER_EN
        io_write(PORT_RLD_LO, 8'd2);
        io_write(PORT_CTRL, 8'h01);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.tx_valid, bus.tx_data, int_out} !== 10'h0 ||
            {out_reg0, out_reg1, out_reg2, out_reg3} !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset_outputs: valid=%b data=%h int=%b regs=%h expected all zero",
                     bus.tx_valid, bus.tx_data, int_out, {out_reg0, out_reg1, out_reg2, out_reg3});
        end
        io_read(PORT_STATUS, rd);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL midop_reset_status: got %h expected 01", rd);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        io_read(PORT_TXCNT, rd);
        vectors++;
        if (rd !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midop_reset_count: got %h expected 00", rd);
        end
`ifdef RAT_IO_TIMER_EN
        io_write(PORT_CTRL, 8'h01);
        n = 0;
        while (int_out !== 1'b1 && n < 60000) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n !== 50000) begin
            miscompares++;
            $display("[TB] FAIL midop_reload_period: got %0d cycles expected 50000", n);
        end
`else
        n = 0;
`endif
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        sw_in        = 8'h00;
        bus.port_id  = 8'hFF;
        bus.out_port = 8'h00;
        bus.io_strb  = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_latches();
        test_fifo_fill_drain();
        test_back_to_back();
`ifdef RAT_IO_TIMER_EN
        test_timer();
`else
        test_macro_off();
`endif
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rat_port_responder.md
# rat_port_responder

Responder end of the CPU's port I/O bus: it decodes `port_id`, captures `out_port` on `io_strb`, and drives `in_port` back for `IN` instructions. It holds four general output latches and an 8-deep transmit FIFO, which a downstream consumer drains over a valid/ready handshake. An optional interval timer raises the CPU's `input_interrupt` as a single-cycle pulse. It sits beside the pipelined CPU at the top level.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO depth; must be a power of 2, at least 2.
- `TIMER_RELOAD_RST`, 16'd49999: reset value of the timer reload register.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `port_id` input 8: port address from the CPU, valid in the execute-stage cycle.
- `out_port` input 8: write data from the CPU, aligned with `port_id`.
- `io_strb` input 1: one-cycle write strobe, aligned with `port_id`.
- `in_port` output 8: read data, combinational from `port_id`.
- `sw_in` input 8: external switch byte, readable at port 0x20.
- `out_reg0`–`out_reg3` output 8 each: general output latches.
- `tx_data` output 8: FIFO head byte.
- `tx_valid` output 1: FIFO is not empty.
- `tx_ready` input 1: consumer accepts `tx_data`.
- `int_out` output 1: single-cycle interrupt pulse to the CPU.

## Operation
- **Write map**, active only when `io_strb` is high:
  - 0x00–0x03: `out_regN` ← `out_port`.
  - 0x10: push into the TX FIFO.
  - 0x11: control. Bit0 sets `timer_en`. Bit1=1 acks the interrupt (clears `pending`). Bit2=1 clears `tx_ovf`.
  - 0x12: reload[7:0]. 0x13: reload[15:8].
  - Any other address is ignored.
- **Read map** (`in_port`):
  - 0x20: `sw_in`.
  - 0x21: status {3'b0, `timer_en`, `pending`, `tx_ovf`, `tx_full`, `tx_empty`}.
  - 0x22: FIFO occupancy, zero-extended.
  - 0x11: {7'b0, `timer_en`}.
  - Unmapped addresses return 0x00.
  - Reads have no side effects; `io_strb` is ignored for reads.
- **FIFO**:
  - Push when `io_strb && port_id==0x10`. Pop when `tx_valid && tx_ready`.
  - Pushing while full drops the byte and sets sticky `tx_ovf`, unless a pop occurs in the same cycle; then the push is accepted and occupancy is unchanged.
  - Push and pop on an empty FIFO: push only; occupancy becomes 1.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy is log2(`FIFO_DEPTH`)+1 bits wide.
- **Timer**:
  - A 16-bit down-counter, active only while `timer_en`=1. The period is reload+1 cycles, so reload=0 expires every cycle.
  - On expiry: the counter reloads and `pending` is set.
  - Next state: `pending` ← expiry | (`pending` & !ack).
  - `int_out` ← expiry & (!`pending` | ack), registered. An expiry arriving while an interrupt is pending and unacked produces no pulse.
  - Writing reload does not disturb the running count; the new value takes effect at the next expiry.
  - Writing `timer_en` 0→1 loads the counter from reload.
  - While `timer_en`=0 the counter holds.

## Timing
- Reset values: `out_reg0`–`out_reg3`=0x00, FIFO empty (`tx_valid`=0, `tx_data`=0x00), `tx_ovf`=0, `pending`=0, `int_out`=0, `timer_en`=0, reload=`TIMER_RELOAD_RST`, counter=`TIMER_RELOAD_RST`.
- Assertion of `rst_n` mid-operation clears all state immediately; FIFO contents are discarded.
- Output latch write: `out_regN` updates on the edge that ends the strobe cycle.
- FIFO push: `tx_valid`/`tx_data` are visible the following cycle. The FIFO is first-word fall-through; `tx_data` is stable while `tx_valid && !tx_ready`.
- `in_port` is combinational, with zero-cycle latency from `port_id`, so it is captured by the CPU writeback register in the same cycle.
- `int_out` is high for exactly one cycle. The CPU forces the ISR vector for exactly the cycles `input_interrupt` is high.

## Configuration
- Macro `RAT_IO_TIMER_EN`.
- Defined: the timer, reload registers, `pending` and `int_out` logic are present.
- Undefined:
  - These are all absent and `int_out` is tied to 0.
  - Writes to 0x12/0x13 and control bits 0–1 are ignored.
  - Status bits 3–4 and port 0x11 read 0.
  - Control bit2 (`tx_ovf` clear) still works.

## Structure
- Package `rat_io_pkg` holds:
  - the port address localparams (`PORT_OUT0`..`PORT_OUT3`, `PORT_TX`, `PORT_CTRL`, `PORT_RLD_LO`, `PORT_RLD_HI`, `PORT_SW`, `PORT_STATUS`, `PORT_TXCNT`);
  - the control/status bit index constants.
- Sub-module `rat_io_fifo` implements the parameterised synchronous FWFT FIFO, with push/pop/full/empty/count/overflow outputs.

## Test plan
- **Output latches:** strobe 0x02 with 0xA5 → `out_reg2`=0xA5 next cycle; other latches unchanged. Strobe 0x07 → no change.
- **FIFO fill and drain:** with `tx_ready`=0, push 0x01..0x09 → count reads 8, status=0x06 (`tx_full`, `tx_ovf`). Then raise `tx_ready` → 0x01..0x08 appear in order, and status reads 0x05 once empty.
- **Simultaneous push/pop:** full FIFO, `tx_ready`=1 and push 0x55 in the same cycle → no overflow, count stays 8, and 0x55 is the last byte out.
- **Timer interrupt:** reload=3, enable → `int_out` pulses one cycle every 4 cycles only while acked. Without an ack, `pending`=1 and there are no further pulses. Ack coinciding with expiry → pulse on the next cycle.
- **Reset mid-operation:** assert `rst_n`=0 while the FIFO holds 3 bytes and the timer is running → all outputs return to reset values immediately; reload reads back 49999 via timer behaviour.
- **Macro-off build:** without `RAT_IO_TIMER_EN`, write 0x11=0x03 → `int_out` stays 0 and status reads 0x01.
